// File: rtl/sram_arbiter_pkg.sv
// Shared types and widths for the two-requester SRAM arbiter.
package sram_arbiter_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        FREE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester handshakes plus the SRAM port of the arbiter, bundled as one interface.
interface sram_arbiter_if;
    import sram_arbiter_pkg::*;

    logic              r0_req;
    logic              r0_we;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic              r0_lock;
    logic              r0_gnt;
    logic              r0_rvalid;

    logic              r1_req;
    logic              r1_we;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic              r1_lock;
    logic              r1_gnt;
    logic              r1_rvalid;

    logic [DATA_W-1:0] rdata;

    logic [ADDR_W-1:0] sram_a;
    logic [DATA_W-1:0] sram_d;
    logic              sram_wen;
    logic [DATA_W-1:0] sram_q;

    // Arbiter side
    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata, r0_lock,
        input  r1_req, r1_we, r1_addr, r1_wdata, r1_lock,
        output r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, rdata,
        output sram_a, sram_d, sram_wen,
        input  sram_q
    );

    // Requesters and SRAM side
    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata, r0_lock,
        output r1_req, r1_we, r1_addr, r1_wdata, r1_lock,
        input  r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, rdata,
        input  sram_a, sram_d, sram_wen,
        output sram_q
    );

endinterface

// File: rtl/sram_arbiter_rr_pick.sv
// Two-input round-robin picker: ptr=0 favours req[0], ptr=1 favours req[1] on contention.
module rr_pick (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    // One-hot grant selection
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates two requesters onto one single-port SRAM with round-robin and lock ownership.
module sram_arbiter
    import sram_arbiter_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    sram_arbiter_if.slave  bus
);

    arb_state_e        state_r;
    arb_state_e        next_state_s;
    logic              rr_ptr_r;
    logic [1:0]        req_s;
    logic [1:0]        rr_gnt_s;
    logic [1:0]        gnt_s;
    logic              acc_s;
    logic              sel_r1_s;
    logic              sel_we_s;
    logic              sel_lock_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;

    logic [ADDR_W-1:0] sram_a_r;
    logic [DATA_W-1:0] sram_d_r;
    logic              sram_wen_r;
    logic              rd_v1_r;
    logic              rd_own1_r;
    logic              rvalid0_r;
    logic              rvalid1_r;

    assign req_s = {bus.r1_req, bus.r0_req};

    rr_pick u_rr_pick (
        .req (req_s),
        .ptr (rr_ptr_r),
        .gnt (rr_gnt_s)
    );

    // Grant: contention in FREE, only the owner may be granted while locked
    always_comb begin
        gnt_s = 2'b00;
        case (state_r)
            FREE:    gnt_s = rr_gnt_s;
            OWN0:    gnt_s = {1'b0, bus.r0_req};
            OWN1:    gnt_s = {bus.r1_req, 1'b0};
            default: gnt_s = 2'b00;
        endcase
    end

    // Grants are forced low whenever reset is held, without waiting for a clock
    assign bus.r0_gnt = gnt_s[0] & reset;
    assign bus.r1_gnt = gnt_s[1] & reset;

    assign acc_s    = |(req_s & gnt_s);
    assign sel_r1_s = gnt_s[1];

    // Command mux for the granted requester
    always_comb begin
        sel_we_s    = 1'b0;
        sel_lock_s  = 1'b0;
        sel_addr_s  = {ADDR_W{1'b0}};
        sel_wdata_s = {DATA_W{1'b0}};
        if (sel_r1_s) begin
            sel_we_s    = bus.r1_we;
            sel_lock_s  = bus.r1_lock;
            sel_addr_s  = bus.r1_addr;
            sel_wdata_s = bus.r1_wdata;
        end else begin
            sel_we_s    = bus.r0_we;
            sel_lock_s  = bus.r0_lock;
            sel_addr_s  = bus.r0_addr;
            sel_wdata_s = bus.r0_wdata;
        end
    end

    // Ownership FSM next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            FREE: begin
                if (acc_s && sel_lock_s) begin
                    next_state_s = sel_r1_s ? OWN1 : OWN0;
                end else begin
                    next_state_s = FREE;
                end
            end
            OWN0, OWN1: begin
                if (acc_s && !sel_lock_s) begin
                    next_state_s = FREE;
                end else begin
                    next_state_s = state_r;
                end
            end
            default: next_state_s = FREE;
        endcase
    end

    // FSM state and round-robin pointer; only FREE-state accepts move the pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= FREE;
            rr_ptr_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (acc_s && (state_r == FREE)) begin
                rr_ptr_r <= ~sel_r1_s;
            end
        end
    end

    // SRAM command register; address and data hold when idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sram_a_r   <= {ADDR_W{1'b0}};
            sram_d_r   <= {DATA_W{1'b0}};
            sram_wen_r <= 1'b1;
        end else if (acc_s) begin
            sram_a_r   <= sel_addr_s;
            sram_d_r   <= sel_wdata_s;
            sram_wen_r <= ~sel_we_s;
        end else begin
            sram_wen_r <= 1'b1;
        end
    end

    // Two-stage read tag pipeline, independent of ownership state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_v1_r   <= 1'b0;
            rd_own1_r <= 1'b0;
            rvalid0_r <= 1'b0;
            rvalid1_r <= 1'b0;
        end else begin
            rd_v1_r   <= acc_s & ~sel_we_s;
            rd_own1_r <= sel_r1_s;
            rvalid0_r <= rd_v1_r & ~rd_own1_r;
            rvalid1_r <= rd_v1_r & rd_own1_r;
        end
    end

    assign bus.sram_a    = sram_a_r;
    assign bus.sram_d    = sram_d_r;
    assign bus.sram_wen  = sram_wen_r;
    assign bus.r0_rvalid = rvalid0_r;
    assign bus.r1_rvalid = rvalid1_r;
    // SRAM data only lands in the return cycle, so it is passed through, gated by the tag
    assign bus.rdata     = (rvalid0_r | rvalid1_r) ? bus.sram_q : {DATA_W{1'b0}};

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a one-cycle-latency SRAM model.
module tb_sram_arbiter;
    import sram_arbiter_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_run  = 0;
    int   n_fail = 0;

    logic [DATA_W-1:0] mem [0:1023];
    logic              mem_init_done = 1'b0;

    sram_arbiter_if bus ();

    sram_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // SRAM model: write on wen=0, read data appears the cycle after the address is sampled
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int k = 0; k < 1024; k++) begin
                mem[k] <= 8'(k) ^ 8'hA5;
            end
            mem_init_done <= 1'b1;
        end else begin
            if (!bus.sram_wen) begin
                mem[bus.sram_a] <= bus.sram_d;
            end
            bus.sram_q <= mem[bus.sram_a];
        end
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus.r0_req = 1'b0; bus.r0_we = 1'b0; bus.r0_addr = 10'h000; bus.r0_wdata = 8'h00; bus.r0_lock = 1'b0;
        bus.r1_req = 1'b0; bus.r1_we = 1'b0; bus.r1_addr = 10'h000; bus.r1_wdata = 8'h00; bus.r1_lock = 1'b0;
    endtask

    initial begin
        idle_all();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state, grants held low even with requests pending
        bus.r0_req = 1'b1; bus.r1_req = 1'b1;
        #1;
        chk("rst_gnt",   {14'h0, bus.r1_gnt, bus.r0_gnt}, 16'h0000);
        chk("rst_wen",   {15'h0, bus.sram_wen}, 16'h0001);
        chk("rst_a",     {6'h0, bus.sram_a}, 16'h0000);
        chk("rst_rv",    {14'h0, bus.r1_rvalid, bus.r0_rvalid}, 16'h0000);
        chk("rst_rdata", {8'h0, bus.rdata}, 16'h0000);
        idle_all();
        reset = 1'b1;

        // Write 3C to 005 then read it back
        next_cycle();
        bus.r0_req = 1'b1; bus.r0_we = 1'b1; bus.r0_addr = 10'h005; bus.r0_wdata = 8'h3C;
        #1;
        chk("wr_gnt", {14'h0, bus.r1_gnt, bus.r0_gnt}, 16'h0001);
        next_cycle();
        chk("wr_wen", {15'h0, bus.sram_wen}, 16'h0000);
        chk("wr_a",   {6'h0, bus.sram_a}, 16'h0005);
        chk("wr_d",   {8'h0, bus.sram_d}, 16'h003C);
        bus.r0_we = 1'b0;
        #1;
        chk("rd_gnt", {14'h0, bus.r1_gnt, bus.r0_gnt}, 16'h0001);
        next_cycle();
        bus.r0_req = 1'b0;
        chk("rd_wen",   {15'h0, bus.sram_wen}, 16'h0001);
        chk("wr_no_rv", {14'h0, bus.r1_rvalid, bus.r0_rvalid}, 16'h0000);
        next_cycle();
        chk("rd_rv",    {14'h0, bus.r1_rvalid, bus.r0_rvalid}, 16'h0001);
        chk("rd_rdata", {8'h0, bus.rdata}, 16'h003C);
        next_cycle();
        chk("rd_rv_one", {14'h0, bus.r1_rvalid, bus.r0_rvalid}, 16'h0000);

        // Read accepted, then reset asserted mid-cycle T+1
        bus.r0_req = 1'b1; bus.r0_we = 1'b0; bus.r0_addr = 10'h005;
        #1;
        chk("pre_rst_gnt", {14'h0, bus.r1_gnt, bus.r0_gnt}, 16'h0001);
        next_cycle();
        chk("pre_rst_a", {6'h0, bus.sram_a}, 16'h0005);
        bus.r1_req = 1'b1; bus.r1_we = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_wen", {15'h0, bus.sram_wen}, 16'h0001);
        chk("mid_rst_a",   {6'h0, bus.sram_a}, 16'h0000);
        chk("mid_rst_d",   {8'h0, bus.sram_d}, 16'h0000);
        chk("mid_rst_gnt", {14'h0, bus.r1_gnt, bus.r0_gnt}, 16'h0000);
        chk("mid_rst_rv",  {14'h0, bus.r1_rvalid, bus.r0_rvalid}, 16'h0000);
        next_cycle();
        idle_all();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            chk("flush_rv", {14'h0, bus.r1_rvalid, bus.r0_rvalid}, 16'h0000);
        end

        // Round-robin from reset: r0, r1, r0, r1
        bus.r0_req = 1'b1; bus.r0_we = 1'b1; bus.r0_addr = 10'h020; bus.r0_wdata = 8'h10;
        bus.r1_req = 1'b1; bus.r1_we = 1'b1; bus.r1_addr = 10'h021; bus.r1_wdata = 8'h20;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_gnt", {14'h0, bus.r1_gnt, bus.r0_gnt}, (i % 2 == 0) ? 16'h0001 : 16'h0002);
            next_cycle();
            chk("rr_a", {6'h0, bus.sram_a}, (i % 2 == 0) ? 16'h0020 : 16'h0021);
        end
        idle_all();

        // r1 locks with a read, r0 shut out until r1 unlocks with a write
        bus.r1_req = 1'b1; bus.r1_we = 1'b0; bus.r1_addr = 10'h100; bus.r1_lock = 1'b1;
        #1;
        chk("lk_gnt", {14'h0, bus.r1_gnt, bus.r0_gnt}, 16'h0002);
        next_cycle();
        bus.r1_req = 1'b0;
        bus.r0_req = 1'b1; bus.r0_we = 1'b1; bus.r0_addr = 10'h030; bus.r0_wdata = 8'h11;
        #1;
        chk("lk_block1", {14'h0, bus.r1_gnt, bus.r0_gnt}, 16'h0000);
        chk("lk_a",      {6'h0, bus.sram_a}, 16'h0100);
        next_cycle();
        chk("lk_block2", {14'h0, bus.r1_gnt, bus.r0_gnt}, 16'h0000);
        chk("lk_rv",     {14'h0, bus.r1_rvalid, bus.r0_rvalid}, 16'h0002);
        chk("lk_rdata",  {8'h0, bus.rdata}, 16'h00A5);
        bus.r1_req = 1'b1; bus.r1_we = 1'b1; bus.r1_wdata = 8'h5A; bus.r1_lock = 1'b0;
        #1;
        chk("unlk_gnt", {14'h0, bus.r1_gnt, bus.r0_gnt}, 16'h0002);
        next_cycle();
        bus.r1_req = 1'b0;
        #1;
        chk("free_gnt", {14'h0, bus.r1_gnt, bus.r0_gnt}, 16'h0001);
        next_cycle();
        bus.r0_req = 1'b0;
        chk("free_a",   {6'h0, bus.sram_a}, 16'h0030);
        chk("free_wen", {15'h0, bus.sram_wen}, 16'h0000);

        // Back-to-back reads of 000..002 return in order with no bubbles
        for (int i = 0; i < 6; i++) begin
            if (i < 3) begin
                bus.r0_req = 1'b1; bus.r0_we = 1'b0; bus.r0_addr = 10'(i); bus.r0_lock = 1'b0;
            end else begin
                bus.r0_req = 1'b0;
            end
            #1;
            chk("b2b_gnt", {15'h0, bus.r0_gnt}, (i < 3) ? 16'h0001 : 16'h0000);
            chk("b2b_rv", {14'h0, bus.r1_rvalid, bus.r0_rvalid}, (i >= 2 && i < 5) ? 16'h0001 : 16'h0000);
            if (i >= 2 && i < 5) begin
                chk("b2b_rdata", {8'h0, bus.rdata}, {8'h0, 8'(i - 2) ^ 8'hA5});
            end
            next_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
